// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants and control encodings.
//   - OPC_*        : 7-bit major opcodes (also used by the immediate generator)
//   - imm_fmt_e    : immediate format select driven to the immediate generator
//   - pc_src_e     : next-PC source select
//   - wb_sel_e     : register-file write-back source select
//   - alu_op_e     : ALU operation class
//   - ctrl_state_e : multicycle control FSM states
//   - inst_class_e : opcode class produced by ctrl_decode
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_JALR  = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_FUNCT  = 2'd1,
        ALU_PASS_B = 2'd2
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } inst_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode classifier.
//   inst       in  32  instruction register contents
//   inst_class out     opcode class (CLS_ILLEGAL for unsupported opcodes)
//   imm_fmt    out     immediate format for that class (IMM_NONE if illegal)
//   legal      out  1  opcode belongs to a supported class
//   rd_is_zero out  1  destination register is x0
module ctrl_decode
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output inst_class_e inst_class,
    output imm_fmt_e    imm_fmt,
    output logic        legal,
    output logic        rd_is_zero
);

    // Only the opcode and rd fields matter for control sequencing.
    logic unused_fields;
    assign unused_fields = ^inst[31:12];

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        inst_class = CLS_ILLEGAL;
        imm_fmt    = IMM_NONE;
        case (inst[6:0])
            OPC_OP:     begin inst_class = CLS_OP;     imm_fmt = IMM_NONE; end
            OPC_OP_IMM: begin inst_class = CLS_OP_IMM; imm_fmt = IMM_I;    end
            OPC_LOAD:   begin inst_class = CLS_LOAD;   imm_fmt = IMM_I;    end
            OPC_STORE:  begin inst_class = CLS_STORE;  imm_fmt = IMM_S;    end
            OPC_BRANCH: begin inst_class = CLS_BRANCH; imm_fmt = IMM_B;    end
            OPC_JAL:    begin inst_class = CLS_JAL;    imm_fmt = IMM_J;    end
            OPC_JALR:   begin inst_class = CLS_JALR;   imm_fmt = IMM_I;    end
            OPC_LUI:    begin inst_class = CLS_LUI;    imm_fmt = IMM_U;    end
            OPC_AUIPC:  begin inst_class = CLS_AUIPC;  imm_fmt = IMM_U;    end
            default:    ;
        endcase
    end

    assign legal      = (inst_class != CLS_ILLEGAL);
    assign rd_is_zero = (inst[11:7] == 5'd0);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM over one shared memory port.
//   clk, rst           clock; synchronous active-high reset
//   inst               instruction register contents (valid from DECODE)
//   branch_taken       branch comparator result
//   mem_ready          memory completes the current request this cycle
//   mem_req/mem_we     memory request / store strobe
//   mem_addr_sel       0 = PC, 1 = ALU result
//   ir_we              latch fetched word into the instruction register
//   imm_fmt            immediate format (riscv_pkg::imm_fmt_e)
//   alu_src_a/b, alu_op ALU operand selects and operation class
//   pc_we/pc_src       PC update strobe and source
//   rf_we/wb_sel       register-file write strobe and source
//   halted/illegal/bus_err sticky halt status
//   instret            retired-instruction counter (wraps)
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic [2:0]       imm_fmt,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    // Timeout fires when the counter already holds LIMIT-1 waited cycles and
    // this cycle is another wait, i.e. on the LIMIT-th waiting cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    ctrl_state_e state, state_next;
    logic [7:0]  wait_cnt;
    logic        waiting, timeout;
    logic        retire, illegal_set, bus_err_set;

    inst_class_e inst_class;
    imm_fmt_e    dec_fmt;
    logic        legal, rd_is_zero;

    ctrl_decode u_decode (
        .inst       (inst),
        .inst_class (inst_class),
        .imm_fmt    (dec_fmt),
        .legal      (legal),
        .rd_is_zero (rd_is_zero)
    );

    assign waiting = (state == ST_FETCH) || (state == ST_MEM);
    assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_LAST);
    assign halted  = (state == ST_HALT);

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        imm_fmt      = IMM_NONE;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        retire       = 1'b0;
        illegal_set  = 1'b0;
        bus_err_set  = 1'b0;

        // Format and operand selects stay stable from DECODE to the end of
        // the instruction so the unregistered datapath sees constant controls.
        if (state == ST_DECODE || state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            imm_fmt = dec_fmt;
            case (inst_class)
                CLS_OP:     alu_op = ALU_FUNCT;
                CLS_OP_IMM: begin alu_src_b = 1'b1; alu_op = ALU_FUNCT; end
                CLS_LUI:    begin alu_src_b = 1'b1; alu_op = ALU_PASS_B; end
                CLS_AUIPC,
                CLS_JAL:    begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
                CLS_LOAD,
                CLS_STORE,
                CLS_JALR:   alu_src_b = 1'b1;
                default:    ;
            endcase
        end

        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                // A response on the limit cycle still completes the fetch.
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    bus_err_set = 1'b1;
                    state_next  = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (legal) begin
                    state_next = ST_EXEC;
                end else begin
                    illegal_set = 1'b1;
                    state_next  = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (inst_class)
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    CLS_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        rf_we      = 1'b1;
                        wb_sel     = WB_PC4;
                        pc_we      = 1'b1;
                        pc_src     = (inst_class == CLS_JAL) ? PC_IMM : PC_JALR;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                    default: state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (inst_class == CLS_STORE);
                if (mem_ready) begin
                    if (inst_class == CLS_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (timeout) begin
                    bus_err_set = 1'b1;
                    state_next  = ST_HALT;
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                wb_sel     = (inst_class == CLS_LOAD) ? WB_MEM : WB_ALU;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: ;
            default: state_next = ST_FETCH;
        endcase

        // Writes to x0 are architecturally discarded.
        rf_we = rf_we && !rd_is_zero;

        // Side effects are suppressed in the reset cycle, whatever the state.
        if (rst) begin
            mem_req = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            if (illegal_set) begin
                illegal <= 1'b1;
            end
            if (bus_err_set) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over a single shared instruction/data memory port with a req/ready handshake. It drives the immediate-format select into the immediate generator, plus ALU operand selects, PC update, register-file write and memory strobes. It also maintains a retired-instruction counter, and halts on an illegal opcode or a memory timeout.

Parameters:
WAIT_LIMIT, 255, max consecutive cycles mem_req may wait for mem_ready before a bus error (range 1..255)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
inst  in  32  instruction register contents (valid from DECODE onward)
branch_taken  in  1  branch comparator result for current instruction
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request; held until mem_ready or timeout
mem_we  out  1  store when 1, read when 0; valid with mem_req
mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (load/store)
ir_we  out  1  latch fetched word into instruction register
imm_fmt  out  3  immediate format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
alu_src_a  out  1  0 = rs1, 1 = PC
alu_src_b  out  1  0 = rs2, 1 = immediate
alu_op  out  2  0 ADD, 1 funct-decoded R/I op, 2 pass-B (LUI)
pc_we  out  1  PC update strobe
pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
rf_we  out  1  register-file write strobe
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
halted  out  1  sticky; core stopped
illegal  out  1  sticky; halt cause = unsupported opcode
bus_err  out  1  sticky; halt cause = memory timeout
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. On reset the state is FETCH, instret is 0, the wait counter is 0, and halted, illegal and bus_err are 0.
- All strobes (mem_req, ir_we, pc_we, rf_we) are 0 in the reset cycle and in HALT.
- All outputs are a combinational decode of the state and inst, registered only through the state.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ready: ir_we=1, go to DECODE.
- DECODE:
  - imm_fmt is valid from DECODE through the end of the instruction.
  - The opcode classes are OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC.
  - Any other opcode sets illegal=1 and goes to HALT; PC is not updated and instret is not incremented.
- EXEC, by class:
  - OP / OP-IMM / LUI / AUIPC: set operands, go to WB.
  - LOAD / STORE: alu_op=ADD, alu_src_b=1, go to MEM.
  - BRANCH: pc_we=1, pc_src = 1 if branch_taken else 0, instret+1, go to FETCH.
  - JAL / JALR: rf_we=1, wb_sel=2, pc_we=1, pc_src=1 or 2, instret+1, go to FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = (class==STORE).
  - On mem_ready for a store: pc_we=1, pc_src=0, instret+1, go to FETCH.
  - On mem_ready for a load: go to WB.
- WB:
  - rf_we=1, wb_sel = 1 for loads, 0 otherwise.
  - pc_we=1, pc_src=0, instret+1, go to FETCH.
- rd==x0: rf_we is forced to 0.
- Latency with zero-wait memory, counting the first FETCH cycle as cycle 1:
  - ALU/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/JAL/JALR: 3 cycles.
- Wait counter:
  - Increments each cycle in FETCH or MEM while mem_ready=0, and clears on any state change.
  - When it reaches WAIT_LIMIT with mem_ready=0: bus_err=1, go to HALT, mem_req drops the next cycle.
  - If mem_ready=1 arrives in the same cycle the counter reaches the limit, mem_ready wins.
- instret wraps modulo 2^CNT_W.
- HALT is left only by rst. A reset asserted in any state, including mid-handshake, takes effect at the next edge and restarts at FETCH.

Decomposition:
- riscv_pkg holds:
  - the opcode localparams, shared with the immediate generator;
  - imm_fmt_e, pc_src_e, wb_sel_e and alu_op_e;
  - the ctrl_state_e enum.
- Sub-module ctrl_decode: combinational inst to {class, imm_fmt, legal, rd_is_zero}. The FSM instantiates it once.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 -> states FETCH,DECODE,EXEC,WB; imm_fmt=1; rf_we high in cycle 4 only; instret=1.
- LW x2,4(x1) with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_we=0 and mem_addr_sel=1; WB has wb_sel=1; 8 cycles total.
- BEQ (imm_fmt=3): branch_taken=1 -> pc_src=1 in EXEC; repeat with branch_taken=0 -> pc_src=0; both 3 cycles, instret +1 each.
- Opcode 0x7F after fetch -> illegal=1, halted=1, no pc_we or rf_we, instret unchanged; rst returns to FETCH with flags cleared.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> bus_err=1 and HALT after 4 wait cycles. Repeat with mem_ready=1 on the 4th cycle -> no error, ir_we=1.
- rst during MEM of a store -> next cycle FETCH, mem_req=0 during the reset cycle, no pc_we, instret keeps reset value 0.
